fmul_pipe: RTL and testbench

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fpu_pkg.sv | 53 +++++
 rtl/fmul_mant_mult.sv | 12 +
 rtl/fmul_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fmul_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: operand classes, special-result codes,
// flag bit positions and width-generic constant builders.
package fpu_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_QNAN = 2'd1,
        SP_INF  = 2'd2,
        SP_ZERO = 2'd3
    } fp_special_e;

    localparam int FLAGS_W       = 4;
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Constant builders return a 64-bit image; callers size-cast to their width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << frac_w;
        r = r | (64'd1 << (frac_w - 1));
        return r;
    endfunction

    function automatic logic [63:0] fp_inf(input int exp_w, input int frac_w);
        return ((64'd1 << exp_w) - 64'd1) << frac_w;
    endfunction

    // Denormals (exp == 0) classify as ZERO so they are flushed.
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic frac_nz);
        if (exp_zero)
            return ZERO;
        else if (exp_ones)
            return frac_nz ? NAN : INF;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/fmul_mant_mult.sv
// Combinational unsigned mantissa multiplier (hidden bit included by caller).
module fmul_mant_mult #(
    parameter int MW = 24
) (
    input  logic [MW-1:0]   ma_i,
    input  logic [MW-1:0]   mb_i,
    output logic [2*MW-1:0] prod_o
);

    assign prod_o = {{MW{1'b0}}, ma_i} * {{MW{1'b0}}, mb_i};

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with a global stall enable,
// truncate / round-to-nearest-even modes and IEEE-style exception flags.
module fmul_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     a,
    input  logic [EXP_W+FRAC_W:0]     b,
    input  logic                      rnd_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     result,
    output logic [FLAGS_W-1:0]        flags
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS     = XW'(fp_bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]         QNAN     = W'(fp_qnan(EXP_W, FRAC_W));
    localparam logic [W-1:0]         INF_POS  = W'(fp_inf(EXP_W, FRAC_W));

    function automatic logic [MW:0] round_mant(input logic [FRAC_W-1:0] frac,
                                               input logic              guard,
                                               input logic              sticky,
                                               input logic              rne);
        logic inc;
        inc = rne & guard & (sticky | frac[0]);
        return {1'b0, 1'b1, frac} + {{MW{1'b0}}, inc};
    endfunction

    // Returns {flags, result}; saturates to inf / flushes to zero at the range edges.
    function automatic logic [FLAGS_W+W-1:0] pack_result(input logic              sign,
                                                         input fp_special_e       special,
                                                         input logic signed [XW-1:0] exp,
                                                         input logic [FRAC_W-1:0] frac,
                                                         input logic              inexact);
        logic [W-1:0]       res;
        logic [FLAGS_W-1:0] flg;
        res = '0;
        flg = '0;
        unique case (special)
            SP_QNAN: begin
                res              = QNAN;
                flg[FLG_INVALID] = 1'b1;
            end
            SP_INF:  res = {sign, INF_POS[W-2:0]};
            SP_ZERO: res = {sign, {(W-1){1'b0}}};
            default: begin
                if (exp >= EXP_MAX) begin
                    res                = {sign, INF_POS[W-2:0]};
                    flg[FLG_OVERFLOW]  = 1'b1;
                    flg[FLG_INEXACT]   = 1'b1;
                end else if (exp <= EXP_ZERO) begin
                    res                = {sign, {(W-1){1'b0}}};
                    flg[FLG_UNDERFLOW] = 1'b1;
                    flg[FLG_INEXACT]   = 1'b1;
                end else begin
                    res              = {sign, exp[EXP_W-1:0], frac};
                    flg[FLG_INEXACT] = inexact;
                end
            end
        endcase
        return {flg, res};
    endfunction

    logic en;
    logic vld_p0_q, vld_p1_q, vld_p2_q;

    assign en        = ~vld_p2_q | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (en) begin
            vld_p0_q <= in_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    // ---- S1: classify, exponent sum, mantissa product ----
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [FRAC_W-1:0] frac_a, frac_b;
    fp_class_e         cls_a, cls_b;
    fp_special_e       spec_p0_d;
    logic signed [XW-1:0] exp_p0_d;
    logic [PW-1:0]     prod_w;

    assign exp_a  = a[W-2:FRAC_W];
    assign exp_b  = b[W-2:FRAC_W];
    assign frac_a = a[FRAC_W-1:0];
    assign frac_b = b[FRAC_W-1:0];
    assign cls_a  = fp_classify(exp_a == '0, &exp_a, |frac_a);
    assign cls_b  = fp_classify(exp_b == '0, &exp_b, |frac_b);
    assign exp_p0_d = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

    always_comb begin
        spec_p0_d = SP_NONE;
        if (cls_a == NAN || cls_b == NAN)
            spec_p0_d = SP_QNAN;
        else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
            spec_p0_d = SP_QNAN;
        else if (cls_a == INF || cls_b == INF)
            spec_p0_d = SP_INF;
        else if (cls_a == ZERO || cls_b == ZERO)
            spec_p0_d = SP_ZERO;
    end

    fmul_mant_mult #(.MW(MW)) u_mant_mult (
        .ma_i   ({1'b1, frac_a}),
        .mb_i   ({1'b1, frac_b}),
        .prod_o (prod_w)
    );

    logic                 sign_p0_q, rnd_p0_q;
    fp_special_e          spec_p0_q;
    logic signed [XW-1:0] exp_p0_q;
    logic [PW-1:0]        prod_p0_q;

    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            sign_p0_q <= a[W-1] ^ b[W-1];
            rnd_p0_q  <= rnd_mode;
            spec_p0_q <= spec_p0_d;
            exp_p0_q  <= exp_p0_d;
            prod_p0_q <= prod_w;
        end
    end

    // ---- S2: normalise and round ----
    logic                 norm, carry, guard, sticky;
    logic [PW-2:0]        prod_n;
    logic [FRAC_W-1:0]    frac_pre, frac_p1_d;
    logic [MW:0]          rsum;
    logic signed [XW-1:0] exp_p1_d;

    assign norm     = prod_p0_q[PW-1];
    assign prod_n   = norm ? prod_p0_q[PW-2:0] : {prod_p0_q[PW-3:0], 1'b0};
    assign frac_pre = prod_n[PW-2 -: FRAC_W];
    assign guard    = prod_n[PW-2-FRAC_W];
    assign sticky   = |prod_n[PW-3-FRAC_W:0];
    assign rsum     = round_mant(frac_pre, guard, sticky, rnd_p0_q);
    assign carry    = rsum[MW];
    assign frac_p1_d = carry ? rsum[MW-1:1] : rsum[FRAC_W-1:0];
    assign exp_p1_d = exp_p0_q + $signed({{(XW-1){1'b0}}, norm})
                               + $signed({{(XW-1){1'b0}}, carry});

    logic                 sign_p1_q, inx_p1_q;
    fp_special_e          spec_p1_q;
    logic signed [XW-1:0] exp_p1_q;
    logic [FRAC_W-1:0]    frac_p1_q;

    always_ff @(posedge clk) begin
        if (en && vld_p0_q) begin
            sign_p1_q <= sign_p0_q;
            spec_p1_q <= spec_p0_q;
            exp_p1_q  <= exp_p1_d;
            frac_p1_q <= frac_p1_d;
            inx_p1_q  <= guard | sticky;
        end
    end

    // ---- S3: pack, exceptions, output register ----
    logic [FLAGS_W+W-1:0] packed_p2_d;
    logic [W-1:0]         result_q;
    logic [FLAGS_W-1:0]   flags_q;

    assign packed_p2_d = pack_result(sign_p1_q, spec_p1_q, exp_p1_q, frac_p1_q, inx_p1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (en && vld_p1_q) begin
            result_q <= packed_p2_d[W-1:0];
            flags_q  <= packed_p2_d[FLAGS_W+W-1:W];
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        rnd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    fmul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .rnd_mode  (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        acc, got_pop;
    logic [31:0] last_res;
    logic [3:0]  last_flg;
    int          last_lat;
    logic [35:0] exp_q[$];
    int          acc_cyc_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference: exact integer product, then round by comparing the discarded
    // remainder against one half ulp.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic rm);
        int ex, ey, e, sh;
        logic s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, inx;
        longint unsigned mx, my, p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        x_nan  = (ex == 255) && (x[22:0] != 0);
        y_nan  = (ey == 255) && (y[22:0] != 0);
        x_inf  = (ex == 255) && (x[22:0] == 0);
        y_inf  = (ey == 255) && (y[22:0] == 0);
        x_zero = (ex == 0);
        y_zero = (ey == 0);
        if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf))
            return {4'b1000, 32'h7FC00000};
        if (x_inf || y_inf)
            return {4'b0000, s, 8'hFF, 23'd0};
        if (x_zero || y_zero)
            return {4'b0000, s, 31'd0};
        mx = 64'(x[22:0]) + (64'd1 << 23);
        my = 64'(y[22:0]) + (64'd1 << 23);
        p  = mx * my;
        e  = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rm && ((rem > half) || (rem == half && q[0])))
            q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 15))
            0: r[30:0]  = '0;
            1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2: begin r[30:23] = 8'hFF; r[22] = 1'b1; end
            3: r[30:23] = 8'($urandom_range(1, 20));
            4: r[30:23] = 8'($urandom_range(235, 254));
            5: r[30:23] = 8'h00;
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // One clock: settle, score handshakes that the next edge will take, advance.
    task automatic cycle();
        logic [35:0] e;
        #1;
        acc     = in_valid && in_ready;
        got_pop = 1'b0;
        if (out_valid && out_ready) begin
            got_pop  = 1'b1;
            last_res = result;
            last_flg = flags;
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e        = exp_q.pop_front();
                last_lat = cyc - acc_cyc_q.pop_front();
                check("sb_result", result, e[31:0]);
                check("sb_flags", flags, e[35:32]);
            end
        end
        if (acc) begin
            exp_q.push_back(model(op_a, op_b, rnd));
            acc_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 20) begin
            cycle();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic run_dir(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                           input logic rm, input logic [31:0] er, input logic [3:0] ef);
        int n;
        op_a = xa; op_b = xb; rnd = rm;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        check({tag, "_acc"}, acc, 1);
        in_valid = 1'b0;
        got_pop  = 1'b0;
        n = 0;
        while (!got_pop && n < 10) begin
            cycle();
            n++;
        end
        check({tag, "_seen"}, got_pop, 1);
        check({tag, "_lat"}, last_lat, 3);
        check({tag, "_res"}, last_res, er);
        check({tag, "_flg"}, last_flg, ef);
    endtask

    logic [31:0] bp_a[6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'hC0800000, 32'h3FC00000, 32'h41200000};
    logic [31:0] bp_b[6] = '{32'h40000000, 32'h40400000, 32'h3F000000,
                             32'h40A00000, 32'h3FC00000, 32'hBF800000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, sent, pops;
        logic pend;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; rnd = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        run_dir("mul_1p5x2",   32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000);
        run_dir("inf_x_zero",  32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000);
        run_dir("ninf_x_2",    32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'b0000);
        run_dir("overflow",    32'h7F7FFFFF, 32'h40000000, 1'b1, 32'h7F800000, 4'b0101);
        run_dir("underflow",   32'h00800000, 32'h3F000000, 1'b1, 32'h00000000, 4'b0011);
        run_dir("rnd_trunc",   32'h3F800001, 32'h3FFFFFFF, 1'b0, 32'h40000000, 4'b0001);
        run_dir("rnd_rne",     32'h3F800001, 32'h3FFFFFFF, 1'b1, 32'h40000000, 4'b0001);
        run_dir("rnd_up_tr",   32'h3FC00001, 32'h3F800001, 1'b0, 32'h3FC00002, 4'b0001);
        run_dir("rnd_up_rne",  32'h3FC00001, 32'h3F800001, 1'b1, 32'h3FC00003, 4'b0001);
        run_dir("nan_in",      32'h7FC12345, 32'h3F800000, 1'b1, 32'h7FC00000, 4'b1000);
        run_dir("neg_zero",    32'h80000000, 32'h40000000, 1'b1, 32'h80000000, 4'b0000);
        run_dir("denorm_flush",32'h00000001, 32'h40000000, 1'b1, 32'h00000000, 4'b0000);

        // Backpressure: output stalled, pipeline fills with three then stops.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            op_a = bp_a[idx]; op_b = bp_b[idx]; rnd = 1'b1; in_valid = 1'b1;
            cycle();
            if (acc) idx++;
        end
        check("bp_accepted", idx, 3);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 30 && (idx < 6 || exp_q.size() != 0); c++) begin
            if (idx < 6) begin
                op_a = bp_a[idx]; op_b = bp_b[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (acc) idx++;
            if (got_pop) pops++;
        end
        check("bp_all_sent", idx, 6);
        check("bp_all_out", pops, 6);
        drain();

        // Reset with the output stalled and two operations behind it.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_a = bp_a[i]; op_b = bp_b[i]; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        #1;
        check("rst2_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_result", result, 0);
        check("rst2_flags", flags, 0);
        exp_q.delete();
        acc_cyc_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        #1;
        check("rst2_in_ready", in_ready, 1);
        check("rst2_no_stale", out_valid, 0);
        @(negedge clk);

        // Randomized traffic with random input gaps and output stalls.
        sent = 0;
        pend = 1'b0;
        for (int c = 0; c < 4000 && sent < 400; c++) begin
            if (!pend) begin
                op_a = rand_op(); op_b = rand_op(); rnd = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc) begin
                sent++;
                pend = 1'b0;
            end
        end
        check("rand_sent", sent, 400);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
